// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: control end of the countdown chain for the guess-number game.
// Issues the chain load pulse and the prescaled decrement strobe, detects expiry
// and underflow of the chain, and provides start/pause/stop control plus status.
module game_timer_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned TICK_DIV   = 100_000_000,
   parameter int unsigned DIV_WIDTH  = 27,
   parameter int unsigned MIN_VALUE  = 0,
   parameter int unsigned WARN_VALUE = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic [WIDTH-1:0] chain_value,
   input  logic             chain_carry,
   output logic             set,
   output logic             tick,
   output logic             running,
   output logic             timeout,
   output logic             warn,
   output logic             underflow
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(TICK_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] PRESC_ONE  = DIV_WIDTH'(1);
   localparam logic [WIDTH-1:0]     MIN_VAL    = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0]     WARN_VAL   = WIDTH'(WARN_VALUE);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] presc_q, presc_d;
   logic                 underflow_q, underflow_d;

   logic at_min;
   logic at_last;

   // Unsigned full-width compare against the terminal count; end of prescaler period.
   assign at_min  = (chain_value == MIN_VAL);
   assign at_last = (presc_q == PRESC_LAST);

   // State, prescaler and sticky underflow registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         underflow_q <= underflow_d;
      end
   end

   // Next-state logic: stop beats start beats expiry beats pause.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!stop && start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = stop ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (stop)        state_d = ST_IDLE;
            else if (start)  state_d = ST_LOAD;
            else if (at_min) state_d = ST_EXPIRED;
            else if (pause)  state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_LOAD;
            else if (pause) state_d = ST_RUN;
         end
         ST_EXPIRED: begin
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler: advances on every RUN cycle that stays in RUN or enters PAUSE
   // (so a pause costs no run time), holds through PAUSE, zero everywhere else.
   always_comb begin
      presc_d = '0;
      if (state_q == ST_RUN && (state_d == ST_RUN || state_d == ST_PAUSE)) begin
         presc_d = at_last ? '0 : presc_q + PRESC_ONE;
      end else if (state_q == ST_PAUSE && (state_d == ST_PAUSE || state_d == ST_RUN)) begin
         presc_d = presc_q;
      end
   end

   // Underflow latches on any sampled chain carry and is cleared when entering LOAD;
   // a carry on that same edge still wins so it is never lost.
   always_comb begin
      underflow_d = underflow_q;
      if (state_d == ST_LOAD) underflow_d = 1'b0;
      if (chain_carry)        underflow_d = 1'b1;
   end

   // Outputs decoded from the registered state; warn and tick also look at the chain.
   always_comb begin
      set       = 1'b0;
      tick      = 1'b0;
      running   = 1'b0;
      timeout   = 1'b0;
      warn      = 1'b0;
      underflow = underflow_q;
      case (state_q)
         ST_LOAD: set = 1'b1;
         ST_RUN: begin
            running = 1'b1;
            tick    = at_last && !at_min;
            warn    = (chain_value <= WARN_VAL);
         end
         ST_PAUSE:   warn    = (chain_value <= WARN_VAL);
         ST_EXPIRED: timeout = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl with a behavioural down-counting chain.
// Stimulus pushes per-cycle expected output vectors; a negedge monitor pops and compares.
module tb_game_timer_ctrl;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, pause = 1'b0, stop = 1'b0;
   logic [CW-1:0] chain_value;
   logic          chain_carry = 1'b0;
   logic          set, tick, running, timeout, warn, underflow;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Output vector bit masks: {set, tick, running, timeout, warn, underflow}
   localparam logic [5:0] O_S  = 6'b100000;
   localparam logic [5:0] O_T  = 6'b010000;
   localparam logic [5:0] O_R  = 6'b001000;
   localparam logic [5:0] O_TO = 6'b000100;
   localparam logic [5:0] O_W  = 6'b000010;
   localparam logic [5:0] O_U  = 6'b000001;
   localparam logic [5:0] O_0  = 6'b000000;

   typedef struct {
      int         cyc;
      logic [5:0] v;
      string      nm;
   } exp_t;

   exp_t exp_q[$];

   logic [5:0] outs;
   assign outs = {set, tick, running, timeout, warn, underflow};

   game_timer_ctrl #(
      .WIDTH(CW), .TICK_DIV(4), .DIV_WIDTH(3), .MIN_VALUE(0), .WARN_VALUE(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .chain_value(chain_value), .chain_carry(chain_carry),
      .set(set), .tick(tick), .running(running), .timeout(timeout),
      .warn(warn), .underflow(underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Chain model: SET_VALUE=3, decrements on each tick edge.
   always @(posedge clk or negedge rst) begin
      if (!rst)      chain_value <= '0;
      else if (set)  chain_value <= CW'(3);
      else if (tick) chain_value <= chain_value - CW'(1);
   end

   // Monitor: compares every expectation due in the current cycle, mid-cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (e.cyc != cyc || outs !== e.v) begin
            errors++;
            $display("FAIL %s cyc=%0d due=%0d got=%b want=%b", e.nm, cyc, e.cyc, outs, e.v);
         end else begin
            $display("ok   %s cyc=%0d out=%b", e.nm, cyc, outs);
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_rng(input int base, input int lo, input int hi,
                          input logic [5:0] v, input string nm);
      for (int i = lo; i <= hi; i++) begin
         exp_t e;
         e.cyc = base + i;
         e.v   = v;
         e.nm  = nm;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      int b;

      // Reset state
      wait_cyc(2);
      exp_rng(cyc, 0, 0, O_0, "reset");
      rst = 1'b1;

      // Basic run: start at rel 0, ticks at 5/9/13, timeout from 15
      b = cyc + 1;
      exp_rng(b, 0, 0, O_0, "A_idle");
      exp_rng(b, 1, 1, O_S, "A_set");
      exp_rng(b, 2, 4, O_R, "A_run3");
      exp_rng(b, 5, 5, O_R | O_T, "A_tick1");
      exp_rng(b, 6, 8, O_R, "A_run2");
      exp_rng(b, 9, 9, O_R | O_T, "A_tick2");
      exp_rng(b, 10, 12, O_R | O_W, "A_run1_warn");
      exp_rng(b, 13, 13, O_R | O_T | O_W, "A_tick3");
      exp_rng(b, 14, 14, O_R | O_W, "A_min_notick");
      exp_rng(b, 15, 19, O_TO, "A_timeout");
      exp_rng(b, 20, 20, O_0, "A_stop_idle");
      wait_cyc(b);      start = 1'b1;
      wait_cyc(b + 1);  start = 1'b0;
      wait_cyc(b + 19); stop = 1'b1;
      wait_cyc(b + 20); stop = 1'b0;

      // Pause at rel 6, resume at rel 20: expiry moves from 15 to 29
      b = cyc + 1;
      exp_rng(b, 0, 0, O_0, "B_idle");
      exp_rng(b, 1, 1, O_S, "B_set_stale0");
      exp_rng(b, 2, 4, O_R, "B_run3");
      exp_rng(b, 5, 5, O_R | O_T, "B_tick1");
      exp_rng(b, 6, 6, O_R, "B_pause_cmd");
      exp_rng(b, 7, 20, O_0, "B_paused");
      exp_rng(b, 21, 22, O_R, "B_resume");
      exp_rng(b, 23, 23, O_R | O_T, "B_tick2");
      exp_rng(b, 24, 26, O_R | O_W, "B_run1_warn");
      exp_rng(b, 27, 27, O_R | O_T | O_W, "B_tick3");
      exp_rng(b, 28, 28, O_R | O_W, "B_min");
      exp_rng(b, 29, 31, O_TO, "B_timeout");
      exp_rng(b, 32, 32, O_0, "B_stop_idle");
      wait_cyc(b);      start = 1'b1;
      wait_cyc(b + 1);  start = 1'b0;
      wait_cyc(b + 6);  pause = 1'b1;
      wait_cyc(b + 7);  pause = 1'b0;
      wait_cyc(b + 20); pause = 1'b1;
      wait_cyc(b + 21); pause = 1'b0;
      wait_cyc(b + 31); stop = 1'b1;
      wait_cyc(b + 32); stop = 1'b0;

      // Restart in RUN at value 1, pause on a tick cycle, stop from PAUSE
      b = cyc + 1;
      exp_rng(b, 1, 1, O_S, "C_set");
      exp_rng(b, 2, 4, O_R, "C_run3");
      exp_rng(b, 5, 5, O_R | O_T, "C_tick1");
      exp_rng(b, 6, 8, O_R, "C_run2");
      exp_rng(b, 9, 9, O_R | O_T, "C_tick2");
      exp_rng(b, 10, 11, O_R | O_W, "C_run1");
      exp_rng(b, 12, 12, O_S, "C_restart_set");
      exp_rng(b, 13, 15, O_R, "C_reload3");
      exp_rng(b, 16, 16, O_R | O_T, "C_tick_a");
      exp_rng(b, 17, 19, O_R, "C_run2b");
      exp_rng(b, 20, 20, O_R | O_T, "C_pause_on_tick");
      exp_rng(b, 21, 23, O_W, "C_paused_warn");
      exp_rng(b, 24, 25, O_0, "C_stop_idle");
      wait_cyc(b);      start = 1'b1;
      wait_cyc(b + 1);  start = 1'b0;
      wait_cyc(b + 11); start = 1'b1;
      wait_cyc(b + 12); start = 1'b0;
      wait_cyc(b + 20); pause = 1'b1;
      wait_cyc(b + 21); pause = 1'b0;
      wait_cyc(b + 23); stop = 1'b1;
      wait_cyc(b + 24); stop = 1'b0;

      // Underflow latch, clear on LOAD, then asynchronous reset mid-RUN
      b = cyc + 1;
      exp_rng(b, 1, 1, O_S, "D_set");
      exp_rng(b, 2, 3, O_R, "D_run");
      exp_rng(b, 4, 4, O_R | O_U, "D_uflow_set");
      exp_rng(b, 5, 5, O_R | O_T | O_U, "D_uflow_tick");
      exp_rng(b, 6, 6, O_R | O_U, "D_uflow_hold");
      exp_rng(b, 7, 7, O_S, "D_load_clears");
      exp_rng(b, 8, 9, O_R, "D_run_again");
      exp_rng(b, 10, 10, O_R | O_U, "D_uflow_again");
      exp_rng(b, 11, 12, O_0, "D_async_reset");
      wait_cyc(b);      start = 1'b1;
      wait_cyc(b + 1);  start = 1'b0;
      wait_cyc(b + 3);  chain_carry = 1'b1;
      wait_cyc(b + 4);  chain_carry = 1'b0;
      wait_cyc(b + 6);  start = 1'b1;
      wait_cyc(b + 7);  start = 1'b0;
      wait_cyc(b + 9);  chain_carry = 1'b1;
      wait_cyc(b + 10); chain_carry = 1'b0;
      wait_cyc(b + 11);
      #2 rst = 1'b0;
      wait_cyc(b + 13); rst = 1'b1;
      wait_cyc(b + 15);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
